// File: rtl/mode_sequencer.sv
// Display mode sequencer: arbitrates button/IR/host requests and applies them on frame boundaries.
// Define MODE_SEQ_BLANK_EN to blank the output for BLANK_FRAMES frames around each mode switch.
module mode_sequencer #(
    parameter int NUM_MODES    = 6,
    parameter int RESET_MODE   = 1,
    parameter int BLANK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_step,
    input  logic       i_ir_valid,
    input  logic [2:0] i_ir_mode,
    input  logic       i_host_valid,
    input  logic [2:0] i_host_mode,
    input  logic       i_vsync,
    output logic [2:0] o_current_mode,
    output logic       o_mode_changed,
    output logic       o_blank,
    output logic       o_busy,
    output logic       o_req_dropped
);

    localparam logic [3:0] LP_NUM_MODES  = 4'(NUM_MODES);
    localparam logic [2:0] LP_LAST_MODE  = 3'(NUM_MODES - 1);
    localparam logic [2:0] LP_RESET_MODE = 3'(RESET_MODE);

    if (NUM_MODES < 2 || NUM_MODES > 8 || RESET_MODE >= NUM_MODES ||
        BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_param_check
        $error("mode_sequencer: parameter out of range");
    end

`ifdef MODE_SEQ_BLANK_EN
    localparam logic [3:0] LP_LAST_FRAME = 4'(BLANK_FRAMES - 1);
    typedef enum logic [1:0] {StIdle, StArm, StBlank, StSettle} state_e;
`else
    typedef enum logic [0:0] {StIdle, StArm} state_e;
`endif

    state_e     r_state, w_state_d;
    logic       r_vsync_prev;
    logic [2:0] r_cur, w_cur_d;
    logic [2:0] r_tgt, w_tgt_d;
    logic       r_changed, w_changed_d;
    logic       r_dropped, w_dropped_d;
    logic       r_slot_valid, w_slot_valid_d;
    logic       r_slot_btn, w_slot_btn_d;
    logic [2:0] r_slot_mode, w_slot_mode_d;
`ifdef MODE_SEQ_BLANK_EN
    logic       r_blank, w_blank_d;
    logic [3:0] r_frame_cnt, w_frame_cnt_d;
`endif

    logic       w_vs_edge, w_host_ok, w_ir_ok, w_win_valid, w_win_btn, w_multi, w_arb_drop;
    logic [2:0] w_win_mode, w_next_mode;
    logic       w_launch_valid, w_launch_btn;
    logic [2:0] w_launch_mode, w_launch_tgt;

    assign w_vs_edge   = i_vsync & ~r_vsync_prev;
    assign w_host_ok   = i_host_valid && ({1'b0, i_host_mode} < LP_NUM_MODES);
    assign w_ir_ok     = i_ir_valid && ({1'b0, i_ir_mode} < LP_NUM_MODES);
    assign w_win_valid = w_host_ok | w_ir_ok | i_btn_step;
    assign w_win_btn   = ~w_host_ok & ~w_ir_ok;
    assign w_win_mode  = w_host_ok ? i_host_mode : i_ir_mode;
    assign w_multi     = (w_host_ok & w_ir_ok) | ((w_host_ok | w_ir_ok) & i_btn_step);
    assign w_arb_drop  = (i_host_valid & ~w_host_ok) | (i_ir_valid & ~w_ir_ok) | w_multi;
    assign w_next_mode = (r_cur == LP_LAST_MODE) ? 3'd0 : r_cur + 3'd1;

    always_comb begin
        w_state_d      = r_state;
        w_cur_d        = r_cur;
        w_tgt_d        = r_tgt;
        w_changed_d    = 1'b0;
        w_dropped_d    = w_arb_drop;
        w_slot_valid_d = r_slot_valid;
        w_slot_btn_d   = r_slot_btn;
        w_slot_mode_d  = r_slot_mode;
        w_launch_valid = 1'b0;
        w_launch_btn   = 1'b0;
        w_launch_mode  = 3'd0;
        w_launch_tgt   = 3'd0;
`ifdef MODE_SEQ_BLANK_EN
        w_blank_d      = r_blank;
        w_frame_cnt_d  = r_frame_cnt;
`endif
        if (r_state == StIdle) begin
            // The slot is older than any new winner, so it goes first and the winner takes its place.
            if (r_slot_valid) begin
                w_launch_valid = 1'b1;
                w_launch_btn   = r_slot_btn;
                w_launch_mode  = r_slot_mode;
                w_slot_valid_d = w_win_valid;
                w_slot_btn_d   = w_win_btn;
                w_slot_mode_d  = w_win_mode;
            end else if (w_win_valid) begin
                w_launch_valid = 1'b1;
                w_launch_btn   = w_win_btn;
                w_launch_mode  = w_win_mode;
            end
            w_launch_tgt = w_launch_btn ? w_next_mode : w_launch_mode;
            if (w_launch_valid && (w_launch_tgt != r_cur)) begin
                w_tgt_d   = w_launch_tgt;
                w_state_d = StArm;
            end
        end else if (w_win_valid) begin
            w_slot_valid_d = 1'b1;
            w_slot_btn_d   = w_win_btn;
            w_slot_mode_d  = w_win_mode;
            if (r_slot_valid) w_dropped_d = 1'b1;
        end

        case (r_state)
            StIdle: ;
`ifdef MODE_SEQ_BLANK_EN
            StArm: if (w_vs_edge) begin
                w_blank_d     = 1'b1;
                w_frame_cnt_d = 4'd0;
                w_state_d     = StBlank;
            end
            StBlank: if (w_vs_edge) begin
                if (r_frame_cnt == LP_LAST_FRAME) begin
                    w_cur_d     = r_tgt;
                    w_changed_d = 1'b1;
                    w_state_d   = StSettle;
                end else begin
                    w_frame_cnt_d = r_frame_cnt + 4'd1;
                end
            end
            StSettle: if (w_vs_edge) begin
                w_blank_d = 1'b0;
                w_state_d = StIdle;
            end
`else
            StArm: if (w_vs_edge) begin
                w_cur_d     = r_tgt;
                w_changed_d = 1'b1;
                w_state_d   = StIdle;
            end
`endif
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_vsync_prev <= 1'b0;
            r_cur        <= LP_RESET_MODE;
            r_tgt        <= LP_RESET_MODE;
            r_changed    <= 1'b0;
            r_dropped    <= 1'b0;
            r_slot_valid <= 1'b0;
            r_slot_btn   <= 1'b0;
            r_slot_mode  <= 3'd0;
`ifdef MODE_SEQ_BLANK_EN
            r_blank      <= 1'b0;
            r_frame_cnt  <= 4'd0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_vsync_prev <= i_vsync;
            r_cur        <= w_cur_d;
            r_tgt        <= w_tgt_d;
            r_changed    <= w_changed_d;
            r_dropped    <= w_dropped_d;
            r_slot_valid <= w_slot_valid_d;
            r_slot_btn   <= w_slot_btn_d;
            r_slot_mode  <= w_slot_mode_d;
`ifdef MODE_SEQ_BLANK_EN
            r_blank      <= w_blank_d;
            r_frame_cnt  <= w_frame_cnt_d;
`endif
        end
    end

    assign o_current_mode = r_cur;
    assign o_mode_changed = r_changed;
    assign o_busy         = (r_state != StIdle) | r_slot_valid;
    assign o_req_dropped  = r_dropped;
`ifdef MODE_SEQ_BLANK_EN
    assign o_blank        = r_blank;
`else
    assign o_blank        = 1'b0;
`endif

endmodule
